sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM controller (edge-triggered rd/we strobes, level `ready`) between NUM_PORTS requesters, e.g. SPU voice fetch, CPU, DMA.
- Converts each requester's level req/ack handshake into one clean strobe edge toward the controller.
- Waits for the controller's completion, then returns read data and a one-cycle ack to the granted port.
- Sits between the client blocks and the SDRAM controller, in the same clock domain.

Parameters:
NUM_PORTS, 3, number of requesters (2..8)
ADDR_W, 24, word address width (matches controller addr)

Ports:
clk  in  1  system clock (~100 MHz, same as controller)
init  in  1  asynchronous active-high reset
req  in  NUM_PORTS  per-port request level; held until ack
req_we  in  NUM_PORTS  per-port 1=write, 0=read
req_addr  in  NUM_PORTS*ADDR_W  per-port word address, port p at [p*ADDR_W +: ADDR_W]
req_din  in  NUM_PORTS*16  per-port write data
req_wtbt  in  NUM_PORTS*2  per-port byte enables (bit1 high byte, bit0 low byte)
ack  out  NUM_PORTS  one-cycle completion pulse to granted port
dout  out  16  read data; valid when ack pulses for a read, held until next read completes
busy  out  1  high from grant until ack
sd_rd  out  1  read strobe to controller
sd_we  out  1  write strobe to controller
sd_addr  out  ADDR_W  address to controller
sd_din  out  16  write data to controller
sd_wtbt  out  2  byte enables to controller
sd_dout  in  16  controller read data
sd_ready  in  1  controller ready/valid

Behaviour:
- Reset (init high, async): state=IDLE; ack=0; busy=0; sd_rd=sd_we=0; sd_addr=0; sd_din=0; sd_wtbt=0; dout=0; rr_ptr=NUM_PORTS-1.
- All outputs registered.
- States: IDLE, STROBE, SETTLE, WAIT.
- IDLE:
  - Grants only when sd_ready=1 and no ack bit is high this cycle. The ack cycle is a mandatory dead cycle, so a port dropping req after ack is never regranted.
  - Winner: round-robin, first asserted req at index (rr_ptr+1) mod NUM_PORTS upward.
  - On grant: latch winner's addr/din/wtbt onto sd_*; assert sd_we if req_we else sd_rd; busy=1; gnt=winner; rr_ptr=winner; go to STROBE.
- STROBE: deassert sd_rd/sd_we (strobe high exactly 1 cycle); go to SETTLE.
- SETTLE: one cycle, lets the controller's ready fall; go to WAIT.
- WAIT:
  - When sd_ready=1: ack[gnt]=1 for one cycle; if read, dout<=sd_dout; busy=0; go to IDLE.
  - Else remain in WAIT, indefinitely.
- The controller may skip dropping ready on a repeat read of the same address. The SETTLE-then-sample rule completes that case correctly with held data.
- Latency: grant edge to ack = 3 cycles minimum, plus controller time.
- Strobe spacing: at least 3 low cycles between consecutive strobes, so every transaction is a fresh rising edge.
- sd_addr/sd_din/sd_wtbt stay stable from grant through ack.
- Changing a port's inputs while its req is high and not acked is illegal; the arbiter uses the value latched at grant.
- Dropping req before ack does not cancel an in-flight transaction; ack still pulses.
- Reset mid-transaction aborts immediately with no ack. The controller re-initialises on the same init, and the arbiter waits for sd_ready=1 before the first grant (startup ~12k cycles).

Optional Feature:
- Macro SDRAM_ARB_PRIO0_EN.
- Defined: port 0 has absolute priority. If req[0] is eligible in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated by port-0 grants. Round-robin applies among ports 1..NUM_PORTS-1 only.
- Undefined: pure round-robin over all ports.

Test Plan:
- Reset, then hold sd_ready=0 for 100 cycles with req[0]=1 -> no strobe. Raise sd_ready -> sd_rd pulses 1 cycle with sd_addr=req_addr[0].
- Port 1 write, addr 0x123456, din 0xBEEF, wtbt 2'b01 -> sd_we 1-cycle pulse with those values. Model drops ready 1 cycle after strobe for 6 cycles -> ack[1] one cycle after ready returns.
- Port 2 read; model returns 0x5A5A at ready rise -> dout=0x5A5A on ack[2] cycle, held through a following write.
- req=3'b111 continuously -> grant order 0,1,2,0,1,2; no port granted twice in a row; ack bits never overlap.
- Repeat read where the model keeps sd_ready=1 (hit) -> ack 3 cycles after grant with previous data.
- Assert init while in WAIT -> all outputs 0 within the same cycle, no ack. With SDRAM_ARB_PRIO0_EN, req=3'b111 -> port 0 wins every grant.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
// Bundles the requester-side handshake and the controller-side bus of the
// SDRAM arbiter into one interface.
//   req/req_we/req_addr/req_din/req_wtbt : per-port requests (flattened vectors)
//   ack/dout/busy                        : completion back to the requesters
//   sd_rd/sd_we/sd_addr/sd_din/sd_wtbt   : strobes and payload to the controller
//   sd_dout/sd_ready                     : read data and ready from the controller
// Modports: slave  = the arbiter itself
//           master = the environment (requesters plus controller)
interface sdram_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 24
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        req_we;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*16-1:0]     req_din;
    logic [NUM_PORTS*2-1:0]      req_wtbt;
    logic [NUM_PORTS-1:0]        ack;
    logic [15:0]                 dout;
    logic                        busy;
    logic                        sd_rd;
    logic                        sd_we;
    logic [ADDR_W-1:0]           sd_addr;
    logic [15:0]                 sd_din;
    logic [1:0]                  sd_wtbt;
    logic [15:0]                 sd_dout;
    logic                        sd_ready;

    modport slave (
        input  req, req_we, req_addr, req_din, req_wtbt, sd_dout, sd_ready,
        output ack, dout, busy, sd_rd, sd_we, sd_addr, sd_din, sd_wtbt
    );

    modport master (
        output req, req_we, req_addr, req_din, req_wtbt, sd_dout, sd_ready,
        input  ack, dout, busy, sd_rd, sd_we, sd_addr, sd_din, sd_wtbt
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one SDRAM controller (edge-triggered rd/we strobes, level ready)
// between NUM_PORTS requesters. Each level req is turned into a single
// one-cycle strobe; after the controller completes, the granted port gets a
// one-cycle ack and, for reads, the data on dout.
// Ports:
//   clk  : system clock, same domain as the controller
//   init : asynchronous active-high reset (shared with the controller)
//   bus  : sdram_arbiter_if.slave (requester side and controller side)
// Optional feature: define SDRAM_ARB_PRIO0_EN to give port 0 absolute
// priority; round-robin then covers ports 1..NUM_PORTS-1 only. Without the
// macro arbitration is pure round-robin over all ports.
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 24
) (
    input  logic           clk,
    input  logic           init,
    sdram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, STROBE, SETTLE, WAIT} state_t;

    state_t               state_reg;
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     gnt_reg;
    logic                 gnt_we_reg;
    logic [NUM_PORTS-1:0] ack_reg;
    logic [15:0]          dout_reg;
    logic                 busy_reg;
    logic                 sd_rd_reg;
    logic                 sd_we_reg;
    logic [ADDR_W-1:0]    sd_addr_reg;
    logic [15:0]          sd_din_reg;
    logic [1:0]           sd_wtbt_reg;

    logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
    logic [15:0]          din_arr  [NUM_PORTS];
    logic [1:0]           wtbt_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0] rr_req;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign din_arr[gi]  = bus.req_din[gi*16 +: 16];
            assign wtbt_arr[gi] = bus.req_wtbt[gi*2 +: 2];
`ifdef SDRAM_ARB_PRIO0_EN
            // Port 0 is handled outside the rotation.
            assign rr_req[gi] = (gi == 0) ? 1'b0 : bus.req[gi];
`else
            assign rr_req[gi] = bus.req[gi];
`endif
        end
    endgenerate

    // Round-robin search starting just after the last winner.
    logic             found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] cand;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_PORTS);
            if (!found && rr_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (bus.req[0]) begin
            found   = 1'b1;
            win_idx = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= LAST_PORT;
            gnt_reg     <= '0;
            gnt_we_reg  <= 1'b0;
            ack_reg     <= '0;
            dout_reg    <= '0;
            busy_reg    <= 1'b0;
            sd_rd_reg   <= 1'b0;
            sd_we_reg   <= 1'b0;
            sd_addr_reg <= '0;
            sd_din_reg  <= '0;
            sd_wtbt_reg <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                IDLE: begin
                    // The ack cycle is a dead cycle: the acked port is still
                    // holding req and must not be granted again.
                    if (bus.sd_ready && (ack_reg == '0) && found) begin
                        sd_addr_reg <= addr_arr[win_idx];
                        sd_din_reg  <= din_arr[win_idx];
                        sd_wtbt_reg <= wtbt_arr[win_idx];
                        sd_we_reg   <= bus.req_we[win_idx];
                        sd_rd_reg   <= ~bus.req_we[win_idx];
                        gnt_we_reg  <= bus.req_we[win_idx];
                        gnt_reg     <= win_idx;
                        busy_reg    <= 1'b1;
`ifdef SDRAM_ARB_PRIO0_EN
                        if (win_idx != '0) begin
                            rr_ptr_reg <= win_idx;
                        end
`else
                        rr_ptr_reg  <= win_idx;
`endif
                        state_reg   <= STROBE;
                    end
                end
                STROBE: begin
                    sd_rd_reg <= 1'b0;
                    sd_we_reg <= 1'b0;
                    state_reg <= SETTLE;
                end
                // Gives the controller a cycle to drop ready, so a stale
                // ready from the previous access is never taken as done.
                SETTLE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (bus.sd_ready) begin
                        ack_reg[gnt_reg] <= 1'b1;
                        if (!gnt_we_reg) begin
                            dout_reg <= bus.sd_dout;
                        end
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ack     = ack_reg;
    assign bus.dout    = dout_reg;
    assign bus.busy    = busy_reg;
    assign bus.sd_rd   = sd_rd_reg;
    assign bus.sd_we   = sd_we_reg;
    assign bus.sd_addr = sd_addr_reg;
    assign bus.sd_din  = sd_din_reg;
    assign bus.sd_wtbt = sd_wtbt_reg;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed, table-driven bench for sdram_arbiter (3 ports, 24-bit address).
// Each table row presents a request pattern, plays the controller (ready
// drop length, returned data) and states the expected winner and dout.
// Hand-written sequences cover the no-ready startup hold and reset while a
// transaction is waiting.
module tb_sdram_arbiter;
    localparam int NP = 3;
    localparam int AW = 24;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

    sdram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [23:0] addr;      // port p presents addr + p
        logic [15:0] din;       // port p presents din + p
        logic [1:0]  wtbt;
        int          delay;     // ready-low cycles; 0 = ready stays high
        logic [15:0] rdata;
        int          exp_rr;    // winner, pure round-robin
        int          exp_p0;    // winner, port-0 priority build
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs [13];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_acks = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int ack_cnt = 0;
    int overlap_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.sd_rd || bus.sd_we) strobe_cnt++;
        ack_cnt += $countones(bus.ack);
        if ($countones(bus.ack) > 1 || (bus.sd_rd && bus.sd_we)) overlap_cnt++;
    end

    task automatic check(input int r, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row %0d %s: got %0h want %0h", r, nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.ack, bus.dout, bus.busy, bus.sd_rd, bus.sd_we,
                bus.sd_addr, bus.sd_din, bus.sd_wtbt};
    endfunction

    task automatic drive_ports(input logic [2:0] rq, input logic [2:0] we,
                               input logic [23:0] a, input logic [15:0] d,
                               input logic [1:0] bt);
        for (int p = 0; p < NP; p++) begin
            bus.req_addr[p*AW +: AW] = a + 24'(p);
            bus.req_din[p*16 +: 16]  = d + 16'(p);
            bus.req_wtbt[p*2 +: 2]   = bt;
        end
        bus.req_we = we;
        bus.req    = rq;
    endtask

    task automatic wait_strobe(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.sd_rd || bus.sd_we) seen = 1'b1;
        end
    endtask

    task automatic wait_ack(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.ack != '0) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input int r, input vec_t v);
        int         ep;
        int         g;
        int         lat;
        int         exp_lat;
        bit         seen;
        logic [1:0] epi;
        logic [2:0] ea;
`ifdef SDRAM_ARB_PRIO0_EN
        ep = v.exp_p0;
`else
        ep = v.exp_rr;
`endif
        epi = 2'(ep);
        ea  = 3'b001 << epi;
        exp_lat = (v.delay == 0) ? 3 : v.delay + 2;

        @(negedge clk);
        drive_ports(v.req, v.we, v.addr, v.din, v.wtbt);
        bus.sd_ready = 1'b1;

        wait_strobe(seen);
        check(r, "strobe_seen", 64'(seen), 64'd1);
        if (!seen) return;
        g = cyc;
        check(r, "strobe_kind", 64'({bus.sd_we, bus.sd_rd}), v.we[epi] ? 64'd2 : 64'd1);
        check(r, "sd_addr", 64'(bus.sd_addr), 64'(v.addr + 24'(ep)));
        check(r, "sd_din", 64'(bus.sd_din), 64'(v.din + 16'(ep)));
        check(r, "sd_wtbt", 64'(bus.sd_wtbt), 64'(v.wtbt));
        check(r, "busy_grant", 64'(bus.busy), 64'd1);

        @(posedge clk); #1;
        check(r, "strobe_width", 64'({bus.sd_we, bus.sd_rd}), 64'd0);

        if (v.delay > 0) begin
            @(negedge clk);
            bus.sd_ready = 1'b0;
            repeat (v.delay) @(negedge clk);
            bus.sd_dout  = v.rdata;
            bus.sd_ready = 1'b1;
        end

        wait_ack(seen);
        check(r, "ack_seen", 64'(seen), 64'd1);
        if (!seen) return;
        lat = cyc - g;
        exp_acks++;
        check(r, "ack_port", 64'(bus.ack), 64'(ea));
        check(r, "dout", 64'(bus.dout), 64'(v.exp_dout));
        check(r, "busy_ack", 64'(bus.busy), 64'd0);
        check(r, "sd_addr_hold", 64'(bus.sd_addr), 64'(v.addr + 24'(ep)));
        check(r, "latency", 64'(lat), 64'(exp_lat));
        $display("txn row %0d: port %0d %s addr %h latency %0d dout %h",
                 r, ep, v.we[epi] ? "write" : "read", bus.sd_addr, lat, bus.dout);

        @(negedge clk);
        bus.req[epi] = 1'b0;
        @(posedge clk); #1;
        check(r, "ack_one_cycle", 64'(bus.ack), 64'd0);
        check(r, "dead_cycle", 64'({bus.sd_we, bus.sd_rd}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int s0;
        int a0;

        //          req     we      addr        din       wtbt  dly rdata     rr p0 dout
        vecs[0]  = '{3'b001, 3'b000, 24'h000100, 16'h0000, 2'b11, 3, 16'h1111, 0, 0, 16'h1111};
        vecs[1]  = '{3'b010, 3'b010, 24'h123455, 16'hBEEE, 2'b01, 6, 16'h2222, 1, 1, 16'h1111};
        vecs[2]  = '{3'b100, 3'b000, 24'h0001FE, 16'h3000, 2'b11, 4, 16'h5A5A, 2, 2, 16'h5A5A};
        vecs[3]  = '{3'b001, 3'b001, 24'h000300, 16'hC0DE, 2'b10, 2, 16'hDEAD, 0, 0, 16'h5A5A};
        vecs[4]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 1, 16'h0401, 1, 0, 16'h0401};
        vecs[5]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 2, 16'h0402, 2, 0, 16'h0402};
        vecs[6]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 3, 16'h0403, 0, 0, 16'h0403};
        vecs[7]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 1, 16'h0404, 1, 0, 16'h0404};
        vecs[8]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 2, 16'h0405, 2, 0, 16'h0405};
        vecs[9]  = '{3'b111, 3'b000, 24'h000400, 16'h4000, 2'b11, 1, 16'h0406, 0, 0, 16'h0406};
        vecs[10] = '{3'b001, 3'b000, 24'h000400, 16'h4000, 2'b11, 0, 16'h0000, 0, 0, 16'h0406};
        vecs[11] = '{3'b101, 3'b000, 24'h000500, 16'h0000, 2'b11, 2, 16'h0B0B, 2, 0, 16'h0B0B};
        vecs[12] = '{3'b011, 3'b000, 24'h000600, 16'h0000, 2'b11, 1, 16'h0C0C, 0, 0, 16'h0C0C};

        init         = 1'b1;
        bus.sd_ready = 1'b0;
        bus.sd_dout  = '0;
        drive_ports(3'b000, 3'b000, 24'h0, 16'h0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        check(-1, "reset_outputs", outs(), 64'd0);

        // Controller not ready yet: a held request must not be granted.
        @(negedge clk);
        init = 1'b0;
        drive_ports(3'b001, 3'b000, 24'h000100, 16'h0000, 2'b11);
        s0 = strobe_cnt;
        repeat (100) @(posedge clk);
        #1;
        check(-1, "no_grant_without_ready", 64'(strobe_cnt - s0), 64'd0);
        check(-1, "idle_busy", 64'(bus.busy), 64'd0);

        for (int r = 0; r < 13; r++) begin
            run_vec(r, vecs[r]);
        end

        // Reset while waiting on the controller: immediate clear, no ack.
        @(negedge clk);
        drive_ports(3'b010, 3'b000, 24'h000700, 16'h7000, 2'b11);
        bus.sd_ready = 1'b1;
        wait_strobe(seen);
        check(13, "abort_strobe_seen", 64'(seen), 64'd1);
        @(negedge clk);
        bus.sd_ready = 1'b0;
        repeat (4) @(negedge clk);
        check(13, "busy_in_wait", 64'(bus.busy), 64'd1);
        a0   = ack_cnt;
        init = 1'b1;
        #1;
        check(13, "async_reset_outputs", outs(), 64'd0);
        bus.req      = '0;
        bus.sd_ready = 1'b1;
        repeat (3) @(negedge clk);
        init = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check(13, "no_ack_after_abort", 64'(ack_cnt - a0), 64'd0);
        check(13, "idle_after_abort", 64'(bus.busy), 64'd0);

        // First grant after reset goes to port 0 (pointer back at last port).
        vecs[0] = '{3'b111, 3'b000, 24'h000700, 16'h7000, 2'b11, 2, 16'h7777, 0, 0, 16'h7777};
        run_vec(14, vecs[0]);

        repeat (3) @(posedge clk);
        #1;
        check(15, "ack_never_overlaps", 64'(overlap_cnt), 64'd0);
        check(15, "total_acks", 64'(ack_cnt), 64'(exp_acks));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
